// File: rtl/audio_frame_timer.sv
// rtl/audio_frame_timer.sv - bclk/lrclk/slot/bit timing generator with frame tick and overrun flag; AFT_DIV_PROG_EN adds a runtime divider
module audio_frame_timer #(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32,
    parameter int N_SLOTS   = 2,
    parameter int DIV_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         tdm_mode,
    input  logic                         engine_busy,
    input  logic                         overrun_clr,
`ifdef AFT_DIV_PROG_EN
    input  logic                         div_load,
    input  logic [DIV_W-1:0]             div_value,
`endif
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         bclk_rise,
    output logic                         bclk_fall,
    output logic [$clog2(N_SLOTS)-1:0]   slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         frame_tick,
    output logic                         overrun
);

    localparam int SW = $clog2(N_SLOTS);
    localparam int BW = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_INIT  = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0]    SLOT_LAST = SW'(N_SLOTS - 1);
    localparam logic [SW-1:0]    SLOT_MID  = SW'(N_SLOTS / 2 - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] half_ctr;
    logic             tdm_q;

    logic             wrap;
    logic             rise_n;
    logic             fall_n;
    logic             tick_n;
    logic             lr_n;
    logic             last_bit;
    logic             last_slot;
    logic [BW-1:0]    bit_n;
    logic [SW-1:0]    slot_n;

`ifdef AFT_DIV_PROG_EN
    logic [DIV_W-1:0] div_pend;

    // Loads park in div_pend; the live divider only changes on a half-period wrap so no bclk phase is ever cut short.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div      <= DIV_INIT;
            div_pend <= DIV_INIT;
        end else begin
            if (div_load) begin
                div_pend <= (div_value == '0) ? DIV_ONE : div_value;
            end
            if (enable && wrap) begin
                div <= div_pend;
            end
        end
    end
`else
    assign div = DIV_INIT;
`endif

    // Next-edge decode: half-period wrap, bclk edge, next slot/bit position and next lrclk level.
    always_comb begin
        wrap      = (half_ctr == div - DIV_ONE);
        rise_n    = wrap & ~bclk;
        fall_n    = wrap & bclk;
        last_bit  = (bit_idx == BIT_LAST);
        last_slot = (slot_idx == SLOT_LAST);
        bit_n     = last_bit ? '0 : bit_idx + BW'(1);
        slot_n    = slot_idx;
        if (last_bit) begin
            slot_n = last_slot ? '0 : slot_idx + SW'(1);
        end
        tick_n    = fall_n & last_bit & last_slot;
        lr_n      = lrclk;
        if (tdm_q) begin
            lr_n = (slot_n == SLOT_LAST) && (bit_n == BIT_LAST);
        end else if (bit_n == BIT_LAST) begin
            if (slot_n == SLOT_MID) begin
                lr_n = 1'b1;
            end else if (slot_n == SLOT_LAST) begin
                lr_n = 1'b0;
            end
        end
    end

    // Timing state; idle clears everything here and keeps sampling tdm_mode so a fresh start uses the current mode.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            half_ctr   <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            bclk_rise  <= 1'b0;
            bclk_fall  <= 1'b0;
            slot_idx   <= '0;
            bit_idx    <= '0;
            frame_tick <= 1'b0;
            tdm_q      <= tdm_mode;
        end else begin
            half_ctr   <= wrap ? '0 : half_ctr + DIV_ONE;
            bclk       <= wrap ? ~bclk : bclk;
            bclk_rise  <= rise_n;
            bclk_fall  <= fall_n;
            frame_tick <= tick_n;
            if (fall_n) begin
                bit_idx  <= bit_n;
                slot_idx <= slot_n;
                lrclk    <= lr_n;
            end
            if (tick_n) begin
                tdm_q <= tdm_mode;
            end
        end
    end

    // Sticky overrun: a tick seen while the engine is busy sets it, and a set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (frame_tick && engine_busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_frame_timer.sv
// tb/tb_audio_frame_timer.sv - segment-table stimulus with queued expected outputs for I2S and 8-slot TDM instances
module tb_audio_frame_timer;

    typedef logic [15:0] out_t;

    typedef struct {
        logic rst_n;
        logic en;
        logic busy;
        logic clr;
        int   cycles;
        int   exp_ticks;
        int   exp_tdm_ticks;
        logic exp_ov;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       tdm_mode;
    logic       engine_busy;
    logic       overrun_clr;
    logic       tdm_on;
    logic       busy_t;
    logic       clr_t;

    logic       bclk, lrclk, bclk_rise, bclk_fall, frame_tick, overrun;
    logic [0:0] slot_idx;
    logic [4:0] bit_idx;

    logic       t_bclk, t_lrclk, t_bclk_rise, t_bclk_fall, t_frame_tick, t_overrun;
    logic [2:0] t_slot_idx;
    logic [4:0] t_bit_idx;

`ifdef AFT_DIV_PROG_EN
    logic       div_load;
    logic [7:0] div_value;
    logic       t_div_load;
    logic [7:0] t_div_value;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_cnt    = 0;
    int   ttick_cnt   = 0;
    out_t exp_q[$];
    out_t texp_q[$];
    seg_t segs[13];

    audio_frame_timer u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .tdm_mode    (tdm_mode),
        .engine_busy (engine_busy),
        .overrun_clr (overrun_clr),
`ifdef AFT_DIV_PROG_EN
        .div_load    (div_load),
        .div_value   (div_value),
`endif
        .bclk        (bclk),
        .lrclk       (lrclk),
        .bclk_rise   (bclk_rise),
        .bclk_fall   (bclk_fall),
        .slot_idx    (slot_idx),
        .bit_idx     (bit_idx),
        .frame_tick  (frame_tick),
        .overrun     (overrun)
    );

    audio_frame_timer #(.N_SLOTS(8)) u_tdm (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .tdm_mode    (tdm_on),
        .engine_busy (busy_t),
        .overrun_clr (clr_t),
`ifdef AFT_DIV_PROG_EN
        .div_load    (t_div_load),
        .div_value   (t_div_value),
`endif
        .bclk        (t_bclk),
        .lrclk       (t_lrclk),
        .bclk_rise   (t_bclk_rise),
        .bclk_fall   (t_bclk_fall),
        .slot_idx    (t_slot_idx),
        .bit_idx     (t_bit_idx),
        .frame_tick  (t_frame_tick),
        .overrun     (t_overrun)
    );

    always #5 clk = ~clk;

    // Closed-form timing for divider 4, 32-bit slots: n = clk edges since enable went high (0 = idle/reset).
    // Layout: [13] bclk [12] lrclk [11] rise [10] fall [9] tick [8] overrun [7:5] slot [4:0] bit
    function automatic out_t model(int n, int nslots, bit tdm, logic ov);
        out_t r;
        int   fp;
        int   p;
        r    = '0;
        r[8] = ov;
        if (n == 0) return r;
        fp    = nslots * 32;
        p     = (n / 8) % fp;
        r[13] = ((n / 4) % 2) == 1;
        r[11] = (n % 8) == 4;
        r[10] = (n % 8) == 0;
        r[9]  = (n % (8 * fp)) == 0;
        if (tdm) r[12] = (p == fp - 1);
        else     r[12] = (p >= (nslots / 2) * 32 - 1) && (p < fp - 1);
        r[7:5] = 3'(p / 32);
        r[4:0] = 5'(p % 32);
        return r;
    endfunction

    // Monitor: one edge after the drive, pop the expected record and compare the whole output bundle.
    always @(posedge clk) begin
        out_t e;
        out_t a;
        #1;
        if (frame_tick)   tick_cnt++;
        if (t_frame_tick) ttick_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {2'b00, bclk, lrclk, bclk_rise, bclk_fall, frame_tick, overrun, 2'b00, slot_idx, bit_idx};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL i2s_outputs t=%0t got %h want %h", $time, a, e);
            end
        end
        if (texp_q.size() > 0) begin
            e = texp_q.pop_front();
            a = {2'b00, t_bclk, t_lrclk, t_bclk_rise, t_bclk_fall, t_frame_tick, t_overrun, t_slot_idx, t_bit_idx};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL tdm8_outputs t=%0t got %h want %h", $time, a, e);
            end
        end
    end

    initial begin
        int   n;
        int   t0;
        int   tt0;
        logic ov;
        logic prev_tick;
        out_t e;

        reset_n = 1'b0; enable = 1'b0; tdm_mode = 1'b0; engine_busy = 1'b0; overrun_clr = 1'b0;
        tdm_on = 1'b1; busy_t = 1'b0; clr_t = 1'b0;
`ifdef AFT_DIV_PROG_EN
        div_load = 1'b0; div_value = 8'd0; t_div_load = 1'b0; t_div_value = 8'd0;
`endif

        //           rst_n  en    busy  clr   cycles ticks tdm  ov
        segs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,    3,   0,   0, 1'b0};
        segs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  520,   1,   0, 1'b0};
        segs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0,  510,   1,   0, 1'b1};
        segs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  505,   0,   0, 1'b1};
        segs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0,    1,   1,   0, 1'b1};
        segs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1,    1,   0,   0, 1'b1};
        segs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0,    3,   0,   0, 1'b1};
        segs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1,    1,   0,   0, 1'b0};
        segs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,  295,   0,   0, 1'b0};
        segs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0,    2,   0,   0, 1'b0};
        segs[10] = '{1'b1, 1'b1, 1'b1, 1'b0,  520,   1,   0, 1'b1};
        segs[11] = '{1'b1, 1'b0, 1'b0, 1'b0,   50,   0,   0, 1'b1};
        segs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2100,   4,   1, 1'b1};

        n = 0; ov = 1'b0; prev_tick = 1'b0;
        for (int s = 0; s < 13; s++) begin
            t0  = tick_cnt;
            tt0 = ttick_cnt;
            for (int c = 0; c < segs[s].cycles; c++) begin
                @(negedge clk);
                reset_n     = segs[s].rst_n;
                enable      = segs[s].en;
                engine_busy = segs[s].busy;
                overrun_clr = segs[s].clr;
                if (!reset_n)                      ov = 1'b0;
                else if (prev_tick && engine_busy) ov = 1'b1;
                else if (overrun_clr)              ov = 1'b0;
                n = (reset_n && enable) ? n + 1 : 0;
                e = model(n, 2, 1'b0, ov);
                exp_q.push_back(e);
                prev_tick = e[9];
                texp_q.push_back(model(n, 8, 1'b1, 1'b0));
            end
            @(posedge clk);
            #2;
            vectors++;
            if (tick_cnt - t0 != segs[s].exp_ticks) begin
                miscompares++;
                $display("FAIL seg%0d_ticks got %0d want %0d", s, tick_cnt - t0, segs[s].exp_ticks);
            end
            vectors++;
            if (ttick_cnt - tt0 != segs[s].exp_tdm_ticks) begin
                miscompares++;
                $display("FAIL seg%0d_tdm_ticks got %0d want %0d", s, ttick_cnt - tt0, segs[s].exp_tdm_ticks);
            end
            vectors++;
            if (overrun !== segs[s].exp_ov) begin
                miscompares++;
                $display("FAIL seg%0d_overrun got %b want %b", s, overrun, segs[s].exp_ov);
            end
        end

`ifdef AFT_DIV_PROG_EN
        begin
            int tog[$];
            int want[9];
            int got;
            want = '{4, 6, 8, 10, 12, 14, 15, 16, 17};
            @(negedge clk);
            reset_n = 1'b0; enable = 1'b0;
            @(negedge clk);
            reset_n = 1'b1; enable = 1'b1;
            for (int c = 1; c <= 17; c++) begin
                @(posedge clk);
                #1;
                if (bclk_rise || bclk_fall) tog.push_back(c);
                if (c == 1)  begin div_load = 1'b1; div_value = 8'd2; end
                if (c == 2)  div_load = 1'b0;
                if (c == 12) begin div_load = 1'b1; div_value = 8'd0; end
                if (c == 13) div_load = 1'b0;
            end
            for (int i = 0; i < 9; i++) begin
                got = (i < tog.size()) ? tog[i] : -1;
                vectors++;
                if (got != want[i]) begin
                    miscompares++;
                    $display("FAIL div_prog_toggle%0d got cycle %0d want cycle %0d", i, got, want[i]);
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
